morse_delay_queue: RTL and testbench
====================================

Name: morse_delay_queue

Overview:
Parametrised delayed-release FIFO for Mode 0 (alphabet→Morse). It holds each typed character with its Morse code and length, and releases it only after DELAY_CYCLES have elapsed since it was enqueued. Release uses a valid/ready handshake to a downstream consumer (buzzer driver, LCD row-1 transfer). It adds full/overflow reporting, flush, occupancy count and configurable depth/widths to the existing 16-entry, 2 s queue.

Parameters:
DEPTH, 16, number of entries; power of 2, ≥2
DELAY_CYCLES, 2000000, clk cycles from accept to eligibility; ≥1
CHAR_W, 8, ASCII character width
CODE_W, 5, Morse pattern width
LEN_W, 3, Morse length width
AGE_W, $clog2(DELAY_CYCLES+1), per-entry age counter width (derived, not overridden)

Ports:
clk  in  1  system clock (1 MHz on board)
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries this cycle
in_valid  in  1  producer offers an entry
in_ready  out  1  space available (= !full)
in_char  in  CHAR_W  ASCII character
in_code  in  CODE_W  Morse pattern
in_len  in  LEN_W  Morse length
out_valid  out  1  head entry is present and aged ≥ DELAY_CYCLES
out_ready  in  1  consumer accepts head (e.g. !buzzer_busy)
out_char  out  CHAR_W  head character
out_code  out  CODE_W  head pattern
out_len  out  LEN_W  head length
count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
overflow  out  1  one-cycle pulse: in_valid while full, entry dropped

Behaviour:
- Reset (rst=1 at a clk edge): head=tail=0, count=0, all ages=0, overflow=0. Resulting outputs: empty=1, full=0, in_ready=1, out_valid=0. Array data contents are don't-care.
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap naturally. Occupancy is tracked by count, not by pointer compare, so full vs empty is unambiguous.
- Push: in_valid && in_ready && !flush. Writes the slot at tail, sets its age to 0, tail+1.
- Ageing: on each edge, every occupied slot with age<DELAY_CYCLES increments by 1. Age saturates at DELAY_CYCLES. Unoccupied slots hold.
- out_valid = !empty && age[head]==DELAY_CYCLES. This is combinational from registers.
  - An entry pushed at edge E0 has out_valid=1 after edge E(DELAY_CYCLES), i.e. DELAY_CYCLES cycles of latency.
  - out_* always reflect the head slot; their value is don't-care when empty.
- Pop: out_valid && out_ready && !flush. head+1.
- Simultaneous push and pop: both execute; count unchanged.
- Push while full: not accepted even if a pop happens the same cycle (in_ready=!full only). overflow=1 for that cycle and the entry is lost.
- Flush: highest priority below rst. Clears head=tail=0 and count=0. Any push or pop in the same cycle is ignored; overflow is not raised.
- Stall: entries behind a stalled head keep ageing and saturate. Once the head pops, the next entry is released the following cycle if it has already matured. This gives back-to-back release at consumer pace.
- overflow is registered: it asserts the cycle after the dropped attempt and lasts exactly one cycle per dropped attempt.
- Mode gating (e.g. mode_sw) is done outside the block by qualifying in_valid.

Decomposition:
- Shared package morse_pkg:
  - MORSE_CHAR_W=8, MORSE_CODE_W=5, MORSE_LEN_W=3.
  - morse_sym_t packed struct {char, code, len}.
  - DELAY_2SEC_1MHZ=2000000.
- Sub-module morse_age_slot, instantiated DEPTH times in a generate loop. Per slot it contains:
  - the saturating AGE_W counter, with load-zero on write and enable on occupied;
  - a matured flag output.
- The top of the block holds the pointers, count, the data RAM as a register array, and the handshake logic.

Test Plan:
- Basic delay (DELAY_CYCLES=10, DEPTH=4): push 'A' (code 5'b00010, len 2) at cycle 0 with out_ready=1 → out_valid rises after edge 10, out_char=8'h41, popped at that edge; empty=1 afterwards.
- Back-pressure: push 'E','T' on cycles 0 and 1, out_ready=0 until cycle 30 → out_valid=1 from edge 10 to 30. Pops 'E' at 30 and 'T' at 31, back-to-back; count goes 2→1→0.
- Full/overflow (DEPTH=4): push 5 entries on consecutive cycles → full=1 after the 4th. The 5th is dropped, overflow pulses exactly once, count=4, and release order is entries 1–4.
- Wrap-around: 10 push/pop cycles through DEPTH=4 → FIFO order is preserved across the pointer wrap, each entry is released ≥10 cycles after its push, and count never exceeds 4.
- Flush: 3 entries queued, flush with simultaneous in_valid → next cycle count=0, empty=1, out_valid=0, no overflow. A later push is released 10 cycles after it is accepted.
- Reset mid-operation: rst at cycle 5 with 2 entries ageing → count=0, out_valid=0, overflow=0. The first post-reset push behaves as in the basic delay case.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse symbol widths, payload type and timing constants.
package morse_pkg;

    localparam int unsigned MORSE_CHAR_W    = 8;
    localparam int unsigned MORSE_CODE_W    = 5;
    localparam int unsigned MORSE_LEN_W     = 3;
    localparam int unsigned DELAY_2SEC_1MHZ = 2000000;

    typedef struct packed {
        logic [MORSE_CHAR_W-1:0] ch;
        logic [MORSE_CODE_W-1:0] code;
        logic [MORSE_LEN_W-1:0]  len;
    } morse_sym_t;

endpackage

// File: rtl/morse_age_slot.sv
// Per-slot saturating age counter; flags when the slot's entry has waited long enough.
module morse_age_slot #(
    parameter int unsigned DELAY_CYCLES = 10,
    parameter int unsigned AGE_W        = $clog2(DELAY_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic occupied,
    output logic matured_c
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DELAY_CYCLES);

    logic [AGE_W-1:0] age;

    // A fresh write restarts the count; only live entries age, and they stop at AGE_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else if (load) begin
            age <= '0;
        end else if (occupied && (age != AGE_MAX)) begin
            age <= age + AGE_W'(1);
        end
    end

    assign matured_c = (age == AGE_MAX);

endmodule

// File: rtl/morse_delay_queue.sv
// Delayed-release FIFO: each entry becomes visible downstream only after
// DELAY_CYCLES clocks in the queue, then drains on a valid/ready handshake.
module morse_delay_queue
    import morse_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DELAY_CYCLES = DELAY_2SEC_1MHZ,
    parameter int unsigned CHAR_W       = MORSE_CHAR_W,
    parameter int unsigned CODE_W       = MORSE_CODE_W,
    parameter int unsigned LEN_W        = MORSE_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHAR_W-1:0]        in_char,
    input  logic [CODE_W-1:0]        in_code,
    input  logic [LEN_W-1:0]         in_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHAR_W-1:0]        out_char,
    output logic [CODE_W-1:0]        out_code,
    output logic [LEN_W-1:0]         out_len,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AGE_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CHAR_W-1:0] char_mem [DEPTH];
    logic [CODE_W-1:0] code_mem [DEPTH];
    logic [LEN_W-1:0]  len_mem  [DEPTH];
    logic [DEPTH-1:0]  slot_occ;
    logic [DEPTH-1:0]  slot_mat;
    logic              push;
    logic              pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign in_ready  = !full;
    assign out_valid = !empty && slot_mat[head];
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_char  = char_mem[head];
    assign out_code  = code_mem[head];
    assign out_len   = len_mem[head];

    // Pointers, occupancy and the dropped-write pulse; flush outranks any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            overflow <= in_valid && full;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            char_mem[tail] <= in_char;
            code_mem[tail] <= in_code;
            len_mem[tail]  <= in_len;
        end
    end

    // A slot is live when its distance from head (mod DEPTH) is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] rel;

        assign rel         = PTR_W'(i) - head;
        assign slot_occ[i] = ({1'b0, rel} < count);

        morse_age_slot #(
            .DELAY_CYCLES (DELAY_CYCLES),
            .AGE_W        (AGE_W)
        ) u_age (
            .clk       (clk),
            .rst       (rst),
            .load      (push && (tail == PTR_W'(i))),
            .occupied  (slot_occ[i]),
            .matured_c (slot_mat[i])
        );
    end

endmodule

// File: tb/tb_morse_delay_queue.sv
// Table vectors, directed corner sequences and random traffic against a
// queue-of-timestamps model of the delayed-release FIFO.
module tb_morse_delay_queue;
    import morse_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DLY   = 10;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_char;
    logic [4:0]    in_code;
    logic [2:0]    in_len;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_char;
    logic [4:0]    out_code;
    logic [2:0]    out_len;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;

    morse_delay_queue #(
        .DEPTH        (DEPTH),
        .DELAY_CYCLES (DLY),
        .CHAR_W       (8),
        .CODE_W       (5),
        .LEN_W        (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .in_code   (in_code),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_code  (out_code),
        .out_len   (out_len),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Model: each queued entry remembers the edge number at which it was accepted.
    typedef struct {
        morse_sym_t  sym;
        int unsigned t;
    } ent_t;

    ent_t        mq[$];
    int unsigned edges;
    logic        m_ovf;
    int          n_cmp;
    int          n_bad;

    typedef struct {
        logic       fl;
        logic       iv;
        logic       ordy;
        logic [7:0] ch;
        int         exp_cnt;
        logic       exp_v;
        logic       exp_ovf;
        logic       exp_full;
        logic [7:0] exp_ch;
    } vec_t;

    vec_t vt[15];

    function automatic morse_sym_t mk_sym(input logic [7:0] c);
        morse_sym_t s;
        s.ch   = c;
        s.code = c[4:0] ^ 5'b10101;
        s.len  = c[7:5];
        return s;
    endfunction

    function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
                                input logic [7:0] ch, input int cnt, input logic v,
                                input logic ovf, input logic fu, input logic [7:0] ech);
        vec_t r;
        r.fl = fl; r.iv = iv; r.ordy = ordy; r.ch = ch; r.exp_cnt = cnt;
        r.exp_v = v; r.exp_ovf = ovf; r.exp_full = fu; r.exp_ch = ech;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_valid();
        return (mq.size() != 0) && ((edges - mq[0].t) >= DLY);
    endfunction

    task automatic check_outputs();
        morse_sym_t s;
        chk("count", int'(count), mq.size());
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
        chk("out_valid", int'(out_valid), int'(model_valid()));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (model_valid() && out_valid) begin
            s = mq[0].sym;
            chk("out_char", int'(out_char), int'(s.ch));
            chk("out_code", int'(out_code), int'(s.code));
            chk("out_len", int'(out_len), int'(s.len));
        end
    endtask

    task automatic step(input logic fl, input logic iv, input morse_sym_t s, input logic ordy);
        bit   m_full;
        bit   m_push;
        bit   m_pop;
        ent_t e;
        flush     = fl;
        in_valid  = iv;
        in_char   = s.ch;
        in_code   = s.code;
        in_len    = s.len;
        out_ready = ordy;
        m_full = (mq.size() == DEPTH);
        m_push = iv && !m_full && !fl;
        m_pop  = model_valid() && ordy && !fl;
        @(posedge clk);
        edges++;
        m_ovf = iv && m_full && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                e.sym = s;
                e.t   = edges;
                mq.push_back(e);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, mk_sym(8'h00), ordy);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        edges = 0;
        m_ovf = 1'b0;
        check_outputs();
    endtask

    // Push one symbol with the consumer ready and measure cycles until release.
    task automatic latency_check(input string nm, input logic [7:0] c);
        int lat;
        step(1'b0, 1'b1, mk_sym(c), 1'b1);
        lat = 0;
        while (!out_valid && lat < 30) begin
            idle(1'b1);
            lat++;
        end
        chk({nm, "_latency"}, lat, DLY);
        chk({nm, "_char"}, int'(out_char), int'(c));
        idle(1'b1);
        chk({nm, "_empty_after"}, int'(empty), 1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        edges     = 0;
        m_ovf     = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_char   = '0;
        in_code   = '0;
        in_len    = '0;

        //            fl iv rdy ch     cnt v  ovf full exp_ch
        vt[0]  = mk(0, 1, 0, 8'h41, 1, 0, 0, 0, 8'h00);
        vt[1]  = mk(0, 1, 0, 8'h42, 2, 0, 0, 0, 8'h00);
        vt[2]  = mk(0, 1, 0, 8'h43, 3, 0, 0, 0, 8'h00);
        vt[3]  = mk(0, 1, 0, 8'h44, 4, 0, 0, 1, 8'h00);
        vt[4]  = mk(0, 1, 0, 8'h45, 4, 0, 1, 1, 8'h00);
        vt[5]  = mk(0, 0, 0, 8'h00, 4, 0, 0, 1, 8'h00);
        vt[6]  = mk(0, 0, 0, 8'h00, 4, 0, 0, 1, 8'h00);
        vt[7]  = mk(0, 0, 0, 8'h00, 4, 0, 0, 1, 8'h00);
        vt[8]  = mk(0, 0, 0, 8'h00, 4, 0, 0, 1, 8'h00);
        vt[9]  = mk(0, 0, 0, 8'h00, 4, 0, 0, 1, 8'h00);
        vt[10] = mk(0, 0, 0, 8'h00, 4, 1, 0, 1, 8'h41);
        vt[11] = mk(0, 0, 1, 8'h00, 3, 1, 0, 0, 8'h42);
        vt[12] = mk(0, 0, 1, 8'h00, 2, 1, 0, 0, 8'h43);
        vt[13] = mk(0, 0, 1, 8'h00, 1, 1, 0, 0, 8'h44);
        vt[14] = mk(0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00);

        repeat (2) @(posedge clk);
        do_reset();
        chk("reset_empty", int'(empty), 1);
        chk("reset_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 15; i++) begin
            step(vt[i].fl, vt[i].iv, mk_sym(vt[i].ch), vt[i].ordy);
            chk($sformatf("vec%0d_count", i), int'(count), vt[i].exp_cnt);
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].exp_v));
            chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(vt[i].exp_ovf));
            chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].exp_full));
            if (vt[i].exp_v) chk($sformatf("vec%0d_char", i), int'(out_char), int'(vt[i].exp_ch));
        end

        do_reset();
        latency_check("basic", 8'h41);

        // Stalled consumer: both entries mature, then drain on consecutive cycles.
        do_reset();
        step(1'b0, 1'b1, mk_sym(8'h45), 1'b0);
        step(1'b0, 1'b1, mk_sym(8'h54), 1'b0);
        repeat (28) idle(1'b0);
        chk("bp_valid_held", int'(out_valid), 1);
        chk("bp_count2", int'(count), 2);
        chk("bp_head_E", int'(out_char), 8'h45);
        idle(1'b1);
        chk("bp_count1", int'(count), 1);
        chk("bp_next_valid", int'(out_valid), 1);
        chk("bp_head_T", int'(out_char), 8'h54);
        idle(1'b1);
        chk("bp_count0", int'(count), 0);

        // Flush with a simultaneous push, including from a full queue.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk_sym(8'h30 + 8'(i)), 1'b0);
        step(1'b1, 1'b1, mk_sym(8'h39), 1'b1);
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_overflow", int'(overflow), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, mk_sym(8'h60 + 8'(i)), 1'b0);
        step(1'b1, 1'b1, mk_sym(8'h6f), 1'b0);
        chk("flush_full_overflow", int'(overflow), 0);
        latency_check("post_flush", 8'h52);

        // Reset while entries age and an overflow pulse is pending.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, mk_sym(8'h61 + 8'(i)), 1'b0);
        chk("pre_reset_overflow", int'(overflow), 1);
        do_reset();
        chk("mid_reset_count", int'(count), 0);
        chk("mid_reset_out_valid", int'(out_valid), 0);
        chk("mid_reset_overflow", int'(overflow), 0);
        latency_check("post_reset", 8'h41);

        // Random traffic, including wrap-around, stalls, flushes and resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 79) == 0),
                     ($urandom_range(0, 2) != 0),
                     mk_sym(8'($urandom)),
                     ((i / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
